// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads a 16-word block, then streams W0..W63
// to the round unit under a valid/ready handshake.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_LOAD | accepting message words M0..M15 into the window
// ST_RUN  | presenting W[idx] from win[0]; shifting on each accept
module sha256_msg_schedule (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_word,
    output logic        in_ready,
    output logic        w_valid,
    input  logic        w_ready,
    output logic [31:0] w_out,
    output logic [5:0]  w_idx,
    output logic        w_last,
    output logic        block_done
);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] win [16];
    logic [3:0]  cnt;
    logic [5:0]  idx;
    logic        load_acc;
    logic        run_acc;
    logic [31:0] w_new;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign in_ready = (state == ST_LOAD);
    assign w_valid  = (state == ST_RUN);
    assign load_acc = in_valid & in_ready;
    assign run_acc  = w_valid & w_ready;
    assign w_idx    = idx;
    assign w_last   = w_valid & (idx == 6'd63);

    // Window holds W[t..t+15]; the new tail word is W[t+16].
    assign w_new = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: leave LOAD after M15, leave RUN after W63.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: if (load_acc && cnt == 4'd15) state_nxt = ST_RUN;
            ST_RUN:  if (run_acc && idx == 6'd63)  state_nxt = ST_LOAD;
            default: state_nxt = ST_LOAD;
        endcase
    end

    // Load counter, output index, registered head word and done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= 4'd0;
            idx        <= 6'd0;
            w_out      <= 32'd0;
            block_done <= 1'b0;
        end else begin
            block_done <= run_acc && (idx == 6'd63);
            if (load_acc) begin
                cnt <= cnt + 4'd1;
                if (cnt == 4'd0) begin
                    w_out <= in_word;
                end
                if (cnt == 4'd15) begin
                    idx <= 6'd0;
                end
            end
            if (run_acc) begin
                idx   <= idx + 6'd1;
                w_out <= win[1];
            end
        end
    end

    // Window storage: indexed write while loading, shift while running.
    // Contents are don't-care between blocks, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (load_acc) begin
            win[cnt] <= in_word;
        end else if (run_acc) begin
            for (int i = 0; i < 15; i++) begin
                win[i] <= win[i+1];
            end
            win[15] <= w_new;
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule.
module tb_sha256_msg_schedule;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_word;
    logic        in_ready;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_out;
    logic [5:0]  w_idx;
    logic        w_last;
    logic        block_done;

    sha256_msg_schedule dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_word    (in_word),
        .in_ready   (in_ready),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_out      (w_out),
        .w_idx      (w_idx),
        .w_last     (w_last),
        .block_done (block_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          t;
        logic [31:0] exp;
    } vec_t;

    vec_t        abc_tab [6];
    vec_t        m02_tab [3];
    logic [31:0] msg   [16];
    logic [31:0] ref_w [64];
    logic [31:0] got_w [64];
    int          n_checks;
    int          n_pass;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h want %08h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook recurrence over the full 64-entry array.
    task automatic build_ref();
        for (int t = 0; t < 64; t++) begin
            if (t < 16) ref_w[t] = msg[t];
            else ref_w[t] = (rotr(ref_w[t-2], 17) ^ rotr(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10))
                          + ref_w[t-7]
                          + (rotr(ref_w[t-15], 7) ^ rotr(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3))
                          + ref_w[t-16];
        end
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
        build_ref();
    endtask

    task automatic set_zero();
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        build_ref();
    endtask

    task automatic set_m02();
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[0] = 32'h02000000;
        build_ref();
    endtask

    task automatic chk_reset_state();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_w_valid", {31'd0, w_valid}, 32'd0);
        chk("rst_w_out", w_out, 32'd0);
        chk("rst_w_idx", {26'd0, w_idx}, 32'd0);
        chk("rst_w_last", {31'd0, w_last}, 32'd0);
        chk("rst_block_done", {31'd0, block_done}, 32'd0);
    endtask

    // Called at a negedge in LOAD; returns at the negedge where W0 is shown.
    task automatic load_block(input int rst_at);
        for (int i = 0; i < 16; i++) begin
            chk("load_in_ready", {31'd0, in_ready}, 32'd1);
            if (i == 15) chk("load_no_early_valid", {31'd0, w_valid}, 32'd0);
            in_valid = 1'b1;
            in_word  = msg[i];
            if (i == rst_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset    = 1'b0;
                in_valid = 1'b0;
                chk_reset_state();
                return;
            end
            @(negedge clk);
            if (i == 0) chk("done_one_cycle", {31'd0, block_done}, 32'd0);
        end
        in_valid = 1'b0;
        in_word  = 32'hA5A5A5A5;
        chk("load_latency_valid", {31'd0, w_valid}, 32'd1);
        chk("load_w0", w_out, msg[0]);
    endtask

    // Called at the negedge W0 is shown; returns in the block_done cycle.
    task automatic run_block(input int stall_at, input int stall_len, input int rst_at);
        w_ready = 1'b1;
        for (int t = 0; t < 64; t++) begin
            chk("run_w_valid", {31'd0, w_valid}, 32'd1);
            chk("run_w_idx", {26'd0, w_idx}, t);
            chk("run_w_last", {31'd0, w_last}, {31'd0, t == 63});
            chk("run_done_low", {31'd0, block_done}, 32'd0);
            chk("run_in_ready_low", {31'd0, in_ready}, 32'd0);
            got_w[t] = w_out;
            if (t == rst_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk_reset_state();
                return;
            end
            if (t == stall_at) begin
                w_ready = 1'b0;
                repeat (stall_len) begin
                    @(negedge clk);
                    chk("stall_w_valid", {31'd0, w_valid}, 32'd1);
                    chk("stall_w_out", w_out, got_w[t]);
                    chk("stall_w_idx", {26'd0, w_idx}, t);
                end
                w_ready = 1'b1;
            end
            @(negedge clk);
        end
        chk("done_pulse", {31'd0, block_done}, 32'd1);
        chk("done_in_ready", {31'd0, in_ready}, 32'd1);
        chk("done_w_valid_low", {31'd0, w_valid}, 32'd0);
    endtask

    task automatic cmp_ref(input string name);
        for (int t = 0; t < 64; t++) chk(name, got_w[t], ref_w[t]);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        abc_tab[0] = '{"abc_w0",  0,  32'h61626380};
        abc_tab[1] = '{"abc_w15", 15, 32'h00000018};
        abc_tab[2] = '{"abc_w16", 16, 32'h61626380};
        abc_tab[3] = '{"abc_w17", 17, 32'h000F0000};
        abc_tab[4] = '{"abc_w18", 18, 32'h7DA86405};
        abc_tab[5] = '{"abc_w19", 19, 32'h600003C6};
        m02_tab[0] = '{"m02_w0",  0,  32'h02000000};
        m02_tab[1] = '{"m02_w16", 16, 32'h02000000};
        m02_tab[2] = '{"m02_w17", 17, 32'h00000000};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_word  = 32'h0;
        w_ready  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk_reset_state();

        // "abc" block, no stalls
        set_abc();
        load_block(-1);
        run_block(-1, 0, -1);
        for (int i = 0; i < 6; i++) chk(abc_tab[i].name, got_w[abc_tab[i].t], abc_tab[i].exp);
        cmp_ref("abc_model");
        @(negedge clk);

        // back-pressure at W20 for 5 cycles
        load_block(-1);
        run_block(20, 5, -1);
        cmp_ref("stall_model");
        @(negedge clk);

        // all-zero block
        set_zero();
        load_block(-1);
        run_block(-1, 0, -1);
        for (int t = 0; t < 64; t++) chk("zero_w", got_w[t], 32'h0);

        // M0 = 0x02000000, loaded back-to-back in the block_done cycle
        set_m02();
        load_block(-1);
        run_block(-1, 0, -1);
        for (int i = 0; i < 3; i++) chk(m02_tab[i].name, got_w[m02_tab[i].t], m02_tab[i].exp);
        cmp_ref("m02_model");
        @(negedge clk);

        // reset while running at W30, then a clean abc block
        set_abc();
        load_block(-1);
        run_block(-1, 0, 30);
        load_block(-1);
        run_block(-1, 0, -1);
        cmp_ref("rst_run_model");
        @(negedge clk);

        // reset while loading word 7 of a junk block, then abc
        for (int i = 0; i < 16; i++) msg[i] = 32'hDEAD0000 + i;
        load_block(7);
        set_abc();
        load_block(-1);
        run_block(-1, 0, -1);
        cmp_ref("rst_load_model");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
